cpu_core_param: RTL and testbench
=================================

CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath and register width; legal range 8..32.
REQ-002 The block SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width; legal range 4..12.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_W  fetch address; always equals pc.
REQ-008 imem_ack  input  1  imem_data valid this cycle.
REQ-009 imem_data  input  16  instruction word.
REQ-010 ext_in  input  DATA_W  external operand for LDX.
REQ-011 result  output  DATA_W  last value written to a register.
REQ-012 result_valid  output  1  one-cycle pulse when result updates.
REQ-013 flags  output  4  {Z,N,C,V}.
REQ-014 pc  output  PC_W  current program counter.
REQ-015 halted  output  1  core is stopped by HALT.

Function
REQ-016 Instruction format SHALL be [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2 / shift amount; 8 registers r0..r7, all general purpose.
REQ-017 Opcodes SHALL be: 0 ADD, 1 SUB (rs1-rs2), 2 AND, 3 OR, 4 XOR, 5 NOT rs1, 6 SHL rs1 by [5:3], 7 SHR logical, 8 LDI rd=sext([8:0]), 9 LDX rd=ext_in, A MOV rd=rs1, B CMP (rs1-rs2, flags only), C JMP pc=[11:0], D BRZ (jump if Z), E NOP, F HALT.
REQ-018 The FSM SHALL have states FETCH, DECODE, EXECUTE, HALT.
REQ-019 FETCH: imem_req=1; the FSM holds FETCH, with imem_addr stable, until imem_ack=1, then latches imem_data into IR and moves to DECODE.
REQ-020 DECODE SHALL last 1 cycle, latch rs1/rs2 register values, and move to EXECUTE.
REQ-021 EXECUTE SHALL last 1 cycle: register write, flag update and pc update at its closing edge; next state is FETCH, or HALT for op F.
REQ-022 Minimum instruction latency SHALL be 3 cycles, when imem_ack is high in the first FETCH cycle.
REQ-023 imem_ack SHALL be ignored outside FETCH.
REQ-024 Ops 0-A SHALL write rd, set result to the written value, and pulse result_valid for exactly the cycle after EXECUTE; ops B-F SHALL leave result unchanged with result_valid=0.
REQ-025 Arithmetic SHALL be modulo 2^DATA_W; ADD/SUB/CMP set C (carry out / borrow) and V (signed overflow).
REQ-026 Logic ops, NOT and MOV SHALL set C=V=0.
REQ-027 Shifts SHALL set C to the last bit shifted out, or 0 for shift amount 0; V=0.
REQ-028 Z and N SHALL be computed from the DATA_W-bit result for ops 0-7 and B.
REQ-029 Ops 8-A and C-F SHALL leave flags unchanged.
REQ-030 LDI SHALL sign-extend the 9-bit immediate to DATA_W, truncating when DATA_W<9.
REQ-031 Non-branching instructions SHALL set pc=pc+1, wrapping modulo 2^PC_W.
REQ-032 JMP/BRZ targets SHALL be [11:0] truncated to PC_W bits; BRZ SHALL test the Z value held before this instruction.
REQ-033 Register writes SHALL be visible to the DECODE of the next instruction (no hazards).
REQ-034 HALT state: imem_req=0, halted=1, pc frozen, no register or flag changes; exit only by reset.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL set state=FETCH, pc=RESET_PC, r0..r7=0, flags=0, result=0, result_valid=0, halted=0.
REQ-036 imem_req SHALL be 0 while reset is high.
REQ-037 Reset SHALL override every state, including mid-FETCH with a pending ack: the interrupted instruction SHALL have no effect, and an ack arriving in the reset cycle SHALL be ignored.

Verification
REQ-038 Reset, ack always high, program LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> result 0x0005, 0x0003, 0x0008 on result_valid pulses at cycles 4, 7, 10 after reset deassert; flags=0000.
REQ-039 r1=5, SUB r4,r1,r1; BRZ 0x020 -> Z=1, result 0x0000, next imem_addr=0x20; the same sequence with CMP r1,r2 (5 vs 3) instead -> Z=0, next imem_addr=pc+1.
REQ-040 LDI r1,0x1FF; SHR r2,r1,1; LDI r3,1; ADD r4,r2,r3 -> r1=0xFFFF, r2=0x7FFF with C=1, r4=0x8000 with N=1, V=1, C=0, Z=0.
REQ-041 imem_ack held low 5 cycles in FETCH -> imem_req=1 throughout, imem_addr constant, pc/regs/flags unchanged; instruction completes 3 cycles after ack.
REQ-042 PC_W=4, NOP at address 15 -> next imem_addr=0; HALT -> halted=1, imem_req=0, subsequent ack pulses cause no change until reset.
REQ-043 Reset asserted in the same cycle as imem_ack for ADD -> no register write, result_valid stays 0, pc=RESET_PC, FETCH restarts.

Source files
------------

// File: rtl/cpu_core_param.sv
// Multi-cycle accumulator-free 8-register core: FETCH / DECODE / EXECUTE / HALT,
// one instruction word per fetch, register file read in DECODE, written in EXECUTE.
module cpu_core_param #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic [DATA_W-1:0] ext_in,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [3:0]        flags,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
        OP_LDI, OP_LDX, OP_MOV, OP_CMP, OP_JMP, OP_BRZ, OP_NOP, OP_HALT
    } op_t;

    state_t            r_state;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_flags;
    logic              r_result_valid;
    logic              r_halted;

    op_t               w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_sh;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W:0]   w_shl;
    logic [DATA_W:0]   w_shr;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_wr;
    logic              w_fupd;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_pc_next;

    assign w_op     = op_t'(r_ir[15:12]);
    assign w_rd     = r_ir[11:9];
    assign w_sh     = r_ir[5:3];
    assign w_add    = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub    = {1'b0, r_a} - {1'b0, r_b};
    // Extra guard bit on each shift catches the last bit shifted out (0 when amount is 0).
    assign w_shl    = {1'b0, r_a} << w_sh;
    assign w_shr    = {r_a, 1'b0} >> w_sh;
    assign w_imm    = DATA_W'($signed(r_ir[8:0]));
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = r_ir[PC_W-1:0];

    always_comb begin
        w_res  = r_a;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_wr   = 1'b0;
        w_fupd = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res  = w_add[DATA_W-1:0];
                w_c    = w_add[DATA_W];
                w_v    = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
                w_wr   = 1'b1;
                w_fupd = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                w_res  = w_sub[DATA_W-1:0];
                w_c    = w_sub[DATA_W];
                w_v    = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
                w_wr   = (w_op == OP_SUB);
                w_fupd = 1'b1;
            end
            OP_AND: begin w_res = r_a & r_b; w_wr = 1'b1; w_fupd = 1'b1; end
            OP_OR:  begin w_res = r_a | r_b; w_wr = 1'b1; w_fupd = 1'b1; end
            OP_XOR: begin w_res = r_a ^ r_b; w_wr = 1'b1; w_fupd = 1'b1; end
            OP_NOT: begin w_res = ~r_a;      w_wr = 1'b1; w_fupd = 1'b1; end
            OP_SHL: begin
                w_res  = w_shl[DATA_W-1:0];
                w_c    = w_shl[DATA_W];
                w_wr   = 1'b1;
                w_fupd = 1'b1;
            end
            OP_SHR: begin
                w_res  = w_shr[DATA_W:1];
                w_c    = w_shr[0];
                w_wr   = 1'b1;
                w_fupd = 1'b1;
            end
            OP_LDI: begin w_res = w_imm;  w_wr = 1'b1; end
            OP_LDX: begin w_res = ext_in; w_wr = 1'b1; end
            OP_MOV: begin w_res = r_a;    w_wr = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_JMP:  w_pc_next = w_target;
            OP_BRZ:  w_pc_next = r_flags[3] ? w_target : w_pc_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_FETCH;
            r_pc           <= PC_W'(RESET_PC);
            r_ir           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_flags        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_halted       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[r_ir[8:6]];
                    r_b     <= r_regs[r_ir[5:3]];
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (w_wr) begin
                        r_regs[w_rd]   <= w_res;
                        r_result       <= w_res;
                        r_result_valid <= 1'b1;
                    end
                    if (w_fupd) r_flags <= {(w_res == '0), w_res[DATA_W-1], w_c, w_v};
                    r_pc     <= w_pc_next;
                    r_state  <= (w_op == OP_HALT) ? S_HALT : S_FETCH;
                    r_halted <= (w_op == OP_HALT);
                end
                S_HALT: ;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by reset so it drops within the reset cycle itself.
    assign imem_req     = (r_state == S_FETCH) && !reset;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign flags        = r_flags;
    assign halted       = r_halted;

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed-vector bench for cpu_core_param: default instance plus a PC_W=4 instance
// for PC wrap and HALT behaviour.
module tb_cpu_core_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ext_in;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] result;
    logic        result_valid;
    logic [3:0]  flags;
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] imem_data4;
    logic        imem_req4;
    logic [3:0]  imem_addr4;
    logic [15:0] result4;
    logic        result_valid4;
    logic [3:0]  flags4;
    logic [3:0]  pc4;
    logic        halted4;

    logic [15:0] prog  [256];
    logic [15:0] prog4 [16];

    int n_vec = 0;
    int n_bad = 0;

    cpu_core_param dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ext_in(ext_in),
        .result(result), .result_valid(result_valid), .flags(flags),
        .pc(pc), .halted(halted)
    );

    cpu_core_param #(.DATA_W(16), .PC_W(4), .RESET_PC(14)) dut4 (
        .clk(clk), .reset(reset), .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_ack(imem_ack), .imem_data(imem_data4), .ext_in(ext_in),
        .result(result4), .result_valid(result_valid4), .flags(flags4),
        .pc(pc4), .halted(halted4)
    );

    function automatic logic [15:0] rr(input logic [3:0] op, input int rd, input int rs1, input int rs2);
        return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input logic [8:0] imm);
        return {4'h8, 3'(rd), imm};
    endfunction

    // Memory responds combinationally to the registered fetch address.
    task automatic tick();
        imem_data  = prog[imem_addr];
        imem_data4 = prog4[imem_addr4];
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load_nops();
        for (int i = 0; i < 256; i++) prog[i] = 16'hE000;
        for (int i = 0; i < 16; i++) prog4[i] = 16'hE000;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        ticks(2);
        reset    = 1'b0;
        imem_ack = 1'b1;
    endtask

    task automatic test_reset();
        load_nops();
        reset    = 1'b1;
        imem_ack = 1'b1;
        ticks(2);
        n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_vec++; if (pc !== 8'h00) begin n_bad++; $display("FAIL rst_pc: got %h expected 00", pc); end
        n_vec++; if (result !== 16'h0000 || result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_result: got %h/%b expected 0000/0", result, result_valid); end
        n_vec++; if (flags !== 4'b0000 || halted !== 1'b0) begin n_bad++; $display("FAIL rst_flags_halt: got %b/%b expected 0000/0", flags, halted); end
        n_vec++; if (pc4 !== 4'hE || imem_req4 !== 1'b0) begin n_bad++; $display("FAIL rst_pc4: got %h/%b expected e/0", pc4, imem_req4); end
        reset = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_bad++; $display("FAIL rst_release_req: got %b/%h expected 1/00", imem_req, imem_addr); end
    endtask

    task automatic test_ldi_add();
        logic [15:0] exp_r;
        load_nops();
        prog[0] = ldi(1, 9'h005);
        prog[1] = ldi(2, 9'h003);
        prog[2] = rr(4'h0, 3, 1, 2);
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            tick();
            exp_r = (n == 3) ? 16'h0005 : (n == 6) ? 16'h0003 : 16'h0008;
            n_vec++;
            if (result_valid !== ((n % 3) == 0)) begin
                n_bad++; $display("FAIL add_rv_cycle%0d: got %b expected %b", n + 1, result_valid, (n % 3) == 0);
            end
            if ((n % 3) == 0) begin
                n_vec++; if (result !== exp_r) begin n_bad++; $display("FAIL add_result_cycle%0d: got %h expected %h", n + 1, result, exp_r); end
            end
        end
        n_vec++; if (flags !== 4'b0000 || pc !== 8'h03) begin n_bad++; $display("FAIL add_flags_pc: got %b/%h expected 0000/03", flags, pc); end
    endtask

    task automatic test_branch();
        load_nops();
        prog[0]    = ldi(1, 9'h005);
        prog[1]    = rr(4'h1, 4, 1, 1);
        prog[2]    = {4'hD, 12'h020};
        prog[8'h20] = {4'hC, 12'h3A5};
        do_reset();
        ticks(6);
        n_vec++; if (result !== 16'h0000 || result_valid !== 1'b1 || flags !== 4'b1000) begin
            n_bad++; $display("FAIL sub_zero: got %h/%b/%b expected 0000/1/1000", result, result_valid, flags); end
        ticks(3);
        n_vec++; if (imem_addr !== 8'h20 || result_valid !== 1'b0) begin n_bad++; $display("FAIL brz_taken: got %h/%b expected 20/0", imem_addr, result_valid); end
        ticks(3);
        n_vec++; if (pc !== 8'hA5) begin n_bad++; $display("FAIL jmp_trunc: got %h expected a5", pc); end

        load_nops();
        prog[0] = ldi(1, 9'h005);
        prog[1] = ldi(2, 9'h003);
        prog[2] = rr(4'hB, 0, 1, 2);
        prog[3] = {4'hD, 12'h020};
        prog[4] = rr(4'h1, 5, 2, 1);
        do_reset();
        ticks(9);
        n_vec++; if (result_valid !== 1'b0 || result !== 16'h0003 || flags !== 4'b0000) begin
            n_bad++; $display("FAIL cmp_flags: got %b/%h/%b expected 0/0003/0000", result_valid, result, flags); end
        ticks(3);
        n_vec++; if (imem_addr !== 8'h04) begin n_bad++; $display("FAIL brz_not_taken: got %h expected 04", imem_addr); end
        ticks(3);
        n_vec++; if (result !== 16'hFFFE || flags !== 4'b0110) begin n_bad++; $display("FAIL sub_borrow: got %h/%b expected fffe/0110", result, flags); end
    endtask

    task automatic test_shift_overflow();
        logic [15:0] er [4];
        logic [3:0]  ef [4];
        load_nops();
        prog[0] = ldi(1, 9'h1FF);
        prog[1] = rr(4'h7, 2, 1, 1);
        prog[2] = ldi(3, 9'h001);
        prog[3] = rr(4'h0, 4, 2, 3);
        er[0] = 16'hFFFF; ef[0] = 4'b0000;
        er[1] = 16'h7FFF; ef[1] = 4'b0010;
        er[2] = 16'h0001; ef[2] = 4'b0010;
        er[3] = 16'h8000; ef[3] = 4'b0101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ticks(3);
            n_vec++;
            if (result_valid !== 1'b1 || result !== er[i] || flags !== ef[i]) begin
                n_bad++; $display("FAIL shovf_%0d: got %b/%h/%b expected 1/%h/%b", i, result_valid, result, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [15:0] er [10];
        logic [3:0]  ef [10];
        load_nops();
        ext_in  = 16'hBEEF;
        prog[0] = ldi(1, 9'h1F0);
        prog[1] = ldi(2, 9'h03C);
        prog[2] = rr(4'h2, 3, 1, 2);
        prog[3] = rr(4'h3, 4, 1, 2);
        prog[4] = rr(4'h4, 5, 1, 2);
        prog[5] = rr(4'h5, 6, 1, 0);
        prog[6] = rr(4'h6, 7, 1, 4);
        prog[7] = rr(4'h7, 7, 1, 0);
        prog[8] = rr(4'h9, 0, 0, 0);
        prog[9] = rr(4'hA, 1, 2, 0);
        er[0] = 16'hFFF0; ef[0] = 4'b0000;
        er[1] = 16'h003C; ef[1] = 4'b0000;
        er[2] = 16'h0030; ef[2] = 4'b0000;
        er[3] = 16'hFFFC; ef[3] = 4'b0100;
        er[4] = 16'hFFCC; ef[4] = 4'b0100;
        er[5] = 16'h000F; ef[5] = 4'b0000;
        er[6] = 16'hFF00; ef[6] = 4'b0110;
        er[7] = 16'hFFF0; ef[7] = 4'b0100;
        er[8] = 16'hBEEF; ef[8] = 4'b0100;
        er[9] = 16'h003C; ef[9] = 4'b0100;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ticks(3);
            n_vec++;
            if (result_valid !== 1'b1 || result !== er[i] || flags !== ef[i]) begin
                n_bad++; $display("FAIL logic_%0d: got %b/%h/%b expected 1/%h/%b", i, result_valid, result, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_stall();
        load_nops();
        prog[0] = ldi(1, 9'h005);
        do_reset();
        imem_ack = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || result_valid !== 1'b0 || flags !== 4'b0000) begin
                n_bad++; $display("FAIL stall_%0d: got %b/%h/%b/%b expected 1/00/0/0000", n, imem_req, imem_addr, result_valid, flags);
            end
        end
        imem_ack = 1'b1;
        ticks(2);
        n_vec++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL stall_early: got %b expected 0", result_valid); end
        tick();
        n_vec++; if (result_valid !== 1'b1 || result !== 16'h0005 || pc !== 8'h01) begin
            n_bad++; $display("FAIL stall_done: got %b/%h/%h expected 1/0005/01", result_valid, result, pc); end
    endtask

    task automatic test_wrap_halt();
        load_nops();
        prog4[0] = 16'hF000;
        do_reset();
        ticks(3);
        n_vec++; if (pc4 !== 4'hF) begin n_bad++; $display("FAIL wrap_pc15: got %h expected f", pc4); end
        ticks(3);
        n_vec++; if (imem_addr4 !== 4'h0) begin n_bad++; $display("FAIL wrap_pc0: got %h expected 0", imem_addr4); end
        ticks(3);
        n_vec++; if (halted4 !== 1'b1 || imem_req4 !== 1'b0) begin n_bad++; $display("FAIL halt_enter: got %b/%b expected 1/0", halted4, imem_req4); end
        for (int n = 0; n < 6; n++) begin
            imem_ack = n[0];
            tick();
            n_vec++;
            if (halted4 !== 1'b1 || pc4 !== 4'h1 || result_valid4 !== 1'b0 || imem_req4 !== 1'b0) begin
                n_bad++; $display("FAIL halt_hold_%0d: got %b/%h/%b/%b expected 1/1/0/0", n, halted4, pc4, result_valid4, imem_req4);
            end
        end
        reset = 1'b1;
        tick();
        n_vec++; if (halted4 !== 1'b0 || pc4 !== 4'hE) begin n_bad++; $display("FAIL halt_exit: got %b/%h expected 0/e", halted4, pc4); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        load_nops();
        prog[0] = ldi(1, 9'h005);
        prog[1] = ldi(2, 9'h003);
        prog[2] = rr(4'h0, 3, 1, 2);
        do_reset();
        ticks(6);
        n_vec++; if (result !== 16'h0003 || imem_addr !== 8'h02) begin n_bad++; $display("FAIL midrst_pre: got %h/%h expected 0003/02", result, imem_addr); end
        reset = 1'b1;
        tick();
        n_vec++; if (pc !== 8'h00 || result !== 16'h0000 || result_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL midrst_cut: got %h/%h/%b/%b expected 00/0000/0/0", pc, result, result_valid, imem_req); end
        reset    = 1'b0;
        imem_ack = 1'b0;
        ticks(3);
        n_vec++; if (result_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            n_bad++; $display("FAIL midrst_restart: got %b/%b/%h expected 0/1/00", result_valid, imem_req, imem_addr); end
        prog[0]  = rr(4'hA, 5, 3, 0);
        imem_ack = 1'b1;
        ticks(3);
        n_vec++; if (result_valid !== 1'b1 || result !== 16'h0000 || pc !== 8'h01) begin
            n_bad++; $display("FAIL midrst_r3: got %b/%h/%h expected 1/0000/01", result_valid, result, pc); end
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = 16'h0000;
        imem_data4 = 16'h0000;
        ext_in     = 16'h0000;
        test_reset();
        test_ldi_add();
        test_branch();
        test_shift_overflow();
        test_logic();
        test_stall();
        test_wrap_halt();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
